// File: rtl/snake_engine_fifo.sv
// Snake field engine: moves the snake on a SIZE_X x SIZE_Y grid, buffers turn requests in a small FIFO,
// tracks score/length and runs a request/valid handshake with an external apple position generator.
module snake_engine_fifo #(
  parameter int SIZE_X     = 10,
  parameter int SIZE_Y     = 10,
  parameter int INIT_LEN   = 4,
  parameter int APPLE_X    = 5,
  parameter int APPLE_Y    = 5,
  parameter int WRAP       = 0,
  parameter int DIR_DEPTH  = 2,
  parameter int SCORE_W    = 8,
  parameter int FIELD_SIZE = SIZE_X*SIZE_Y*3,
  parameter int SBITS      = $clog2(SIZE_X*SIZE_Y)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step,
  input  logic [1:0]            dir_in,
  input  logic                  dir_wr,
  input  logic [SBITS-1:0]      apple_pos,
  input  logic                  apple_vld,
  output logic                  apple_req,
  output logic [FIELD_SIZE-1:0] field,
  output logic [SBITS:0]        length,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            state,
  output logic                  busy
);

  localparam int N  = SIZE_X*SIZE_Y;
  localparam int CW = SBITS+1;
  localparam int PW = (DIR_DEPTH > 1) ? $clog2(DIR_DEPTH) : 1;
  localparam int QW = $clog2(DIR_DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_WON} state_t;
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          oob;
  } pos_t;

  state_t        st;
  logic [2:0]    cells [N];
  logic [CW-1:0] head_x, head_y, tail_x, tail_y;
  logic [1:0]    cur_dir;
  logic [1:0]    fifo_mem [DIR_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [QW-1:0] fifo_cnt;

  function automatic logic [SBITS-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return SBITS'(y * CW'(SIZE_X) + x);
  endfunction

  // Neighbour in direction d; coordinates always come back wrapped so the index stays in range,
  // and oob tells a wall-mode caller that the edge was crossed.
  function automatic pos_t move(input logic [1:0] d, input logic [CW-1:0] x, input logic [CW-1:0] y);
    pos_t p;
    p.x   = x;
    p.y   = y;
    p.oob = 1'b0;
    case (d)
      2'd0: if (y == '0) begin p.y = CW'(SIZE_Y-1); p.oob = 1'b1; end
            else p.y = y - CW'(1);
      2'd1: if (x == CW'(SIZE_X-1)) begin p.x = '0; p.oob = 1'b1; end
            else p.x = x + CW'(1);
      2'd2: if (y == CW'(SIZE_Y-1)) begin p.y = '0; p.oob = 1'b1; end
            else p.y = y + CW'(1);
      default: if (x == '0) begin p.x = CW'(SIZE_X-1); p.oob = 1'b1; end
               else p.x = x - CW'(1);
    endcase
    if (WRAP != 0) p.oob = 1'b0;
    return p;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DIR_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  logic             fifo_empty, fifo_full, do_step, push, pop;
  logic [1:0]       pop_dir, nd, tail_dir;
  pos_t             nh, nt;
  logic [SBITS-1:0] h_idx, nh_idx, t_idx;
  logic [2:0]       tgt, nd_code;
  logic             hit_body, eat, die, won, apple_ok;
  logic [SBITS:0]   len_inc;

  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == QW'(DIR_DEPTH));
    do_step    = (st == S_RUN) && !busy && step;
    push       = dir_wr && !fifo_full;
    pop        = do_step && !fifo_empty;
    pop_dir    = fifo_mem[rd_ptr];
    nd         = cur_dir;
    if (!fifo_empty && ((pop_dir ^ cur_dir) != 2'd2)) nd = pop_dir;
    nd_code    = {1'b0, nd} + 3'd1;
    nh         = move(nd, head_x, head_y);
    h_idx      = cell_idx(head_x, head_y);
    nh_idx     = cell_idx(nh.x, nh.y);
    t_idx      = cell_idx(tail_x, tail_y);
    // Codes 1..4 map to directions 0..3; code 4 (3'b100) wraps to 3 in two bits.
    tail_dir   = cells[t_idx][1:0] - 2'd1;
    nt         = move(tail_dir, tail_x, tail_y);
    tgt        = cells[nh_idx];
    // Stepping onto the tail is legal: a body target is never an apple, so the tail moves away.
    hit_body   = (tgt >= 3'd1) && (tgt <= 3'd4) && (nh_idx != t_idx);
    eat        = (tgt == 3'd5) && !nh.oob;
    die        = nh.oob || hit_body;
    len_inc    = length + (SBITS+1)'(1);
    won        = eat && (len_inc == (SBITS+1)'(N));
    apple_ok   = ({1'b0, apple_pos} < CW'(N)) && (cells[apple_pos] == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cells[i] <= 3'd0;
      for (int i = 0; i < DIR_DEPTH; i++) fifo_mem[i] <= 2'd0;
      st        <= S_IDLE;
      head_x    <= '0;
      head_y    <= '0;
      tail_x    <= '0;
      tail_y    <= '0;
      cur_dir   <= 2'd1;
      length    <= '0;
      score     <= '0;
      apple_req <= 1'b0;
      busy      <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
    end else if (start) begin
      for (int i = 0; i < N; i++) begin
        if ((i / SIZE_X == 1) && (i % SIZE_X >= 1) && (i % SIZE_X <= INIT_LEN)) cells[i] <= 3'd2;
        else if (i == APPLE_Y*SIZE_X + APPLE_X) cells[i] <= 3'd5;
        else cells[i] <= 3'd0;
      end
      st        <= S_RUN;
      head_x    <= CW'(INIT_LEN);
      head_y    <= CW'(1);
      tail_x    <= CW'(1);
      tail_y    <= CW'(1);
      cur_dir   <= 2'd1;
      length    <= (SBITS+1)'(INIT_LEN);
      score     <= '0;
      apple_req <= 1'b0;
      busy      <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push) begin
        fifo_mem[wr_ptr] <= dir_in;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      fifo_cnt <= fifo_cnt + QW'(push) - QW'(pop);

      if (do_step) begin
        cur_dir <= nd;
        if (die) begin
          st <= S_DEAD;
        end else begin
          if (!eat) begin
            cells[t_idx] <= 3'd0;
            if (!nt.oob) begin
              tail_x <= nt.x;
              tail_y <= nt.y;
            end
          end
          // Head writes come after the tail clear so a tail chase leaves the head code in place.
          cells[h_idx]  <= nd_code;
          cells[nh_idx] <= nd_code;
          head_x        <= nh.x;
          head_y        <= nh.y;
          if (eat) begin
            length <= len_inc;
            score  <= (score == '1) ? score : score + SCORE_W'(1);
            if (won) st <= S_WON;
            else begin
              apple_req <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
      end else if (apple_req && apple_vld && apple_ok) begin
        cells[apple_pos] <= 3'd5;
        apple_req        <= 1'b0;
        busy             <= 1'b0;
      end
    end
  end

  always_comb begin
    field = '0;
    for (int i = 0; i < N; i++) field[3*i +: 3] = cells[i];
  end

  assign state = st;

endmodule
